// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one mux8 between eight requesters.
// Define MUX8_ARB_PREEMPT_EN to force rotation after MAX_HOLD grant cycles.
module mux8_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state, state_nx;
    logic [2:0] ptr, ptr_nx;
    logic [2:0] sel_nx;
    logic [7:0] gnt_nx;
    logic       vld_nx;
    logic [7:0] cand;
    logic [2:0] pick;
    logic       do_grant;

`ifdef MUX8_ARB_PREEMPT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt, hold_nx;
    logic [7:0] others;
`endif

    // First set bit of r, scanning p+1, p+2, ... wrapping; p itself is last.
    function automatic logic [2:0] rr_pick(input logic [7:0] r,
                                           input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

`ifdef MUX8_ARB_PREEMPT_EN
    assign others = req & ~(8'd1 << sel);
    assign cand   = (state == GRANT && req[sel]) ? others : req;
`else
    assign cand   = req;
`endif

    assign pick = rr_pick(cand, ptr);

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        gnt_nx   = gnt;
        vld_nx   = gnt_valid;
        do_grant = 1'b0;
`ifdef MUX8_ARB_PREEMPT_EN
        hold_nx  = hold_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (|req) do_grant = 1'b1;
            end
            GRANT: begin
                if (req[sel]) begin
`ifdef MUX8_ARB_PREEMPT_EN
                    if (hold_cnt == HOLD_LAST) begin
                        if (|others) do_grant = 1'b1;
                        else hold_nx = 8'd0;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_nx = hold_cnt + 8'd1;
                    end
`endif
                end else if (|req) begin
                    do_grant = 1'b1;
                end else begin
                    state_nx = IDLE;
                    gnt_nx   = 8'h00;
                    vld_nx   = 1'b0;
                end
            end
        endcase
        if (do_grant) begin
            state_nx = GRANT;
            ptr_nx   = pick;
            sel_nx   = pick;
            gnt_nx   = 8'd1 << pick;
            vld_nx   = 1'b1;
`ifdef MUX8_ARB_PREEMPT_EN
            hold_nx  = 8'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            sel       <= 3'd0;
            gnt       <= 8'h00;
            gnt_valid <= 1'b0;
`ifdef MUX8_ARB_PREEMPT_EN
            hold_cnt  <= 8'd0;
`endif
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            sel       <= sel_nx;
            gnt       <= gnt_nx;
            gnt_valid <= vld_nx;
`ifdef MUX8_ARB_PREEMPT_EN
            hold_cnt  <= hold_nx;
`endif
        end
    end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: directed plan plus random requests.
// Honours MUX8_ARB_PREEMPT_EN with MAX_HOLD = 4.
module tb_mux8_rr_arbiter;

    localparam int MAX_HOLD = 4;
    localparam logic [7:0] DATA = 8'b01101001;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       gnt_valid;

    mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst(rst), .req(req),
        .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] gnt;
        logic       vld;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   done  = 0;

    // Reference: who holds the mux, who was served last, how long held.
    int   cur  = -1;
    int   last = 7;
    int   msel = 0;
    int   held = 0;

    function automatic int search(input logic [7:0] r, input int from);
        for (int k = 1; k <= 8; k++) begin
            int i;
            i = (from + k) % 8;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic serve(input logic [7:0] r);
        int i;
        i = search(r, last);
        cur  = i;
        last = i;
        msel = i;
        held = 0;
    endtask

    task automatic model(input logic r, input logic [7:0] rq);
        logic [7:0] oth;
        bit         preempt;
`ifdef MUX8_ARB_PREEMPT_EN
        preempt = 1;
`else
        preempt = 0;
`endif
        if (r) begin
            cur = -1; last = 7; msel = 0; held = 0;
        end else if (cur < 0) begin
            if (rq != 0) serve(rq);
        end else if (rq[cur]) begin
            if (preempt && held == MAX_HOLD - 1) begin
                oth = rq;
                oth[cur] = 1'b0;
                if (oth != 0) serve(oth);
                else held = 0;
            end else if (held < 255) begin
                held++;
            end
        end else if (rq != 0) begin
            serve(rq);
        end else begin
            cur = -1;
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] rq);
        exp_t e;
        rst = r;
        req = rq;
        model(r, rq);
        e.sel = 3'(msel);
        e.gnt = (cur < 0) ? 8'h00 : (8'd1 << cur);
        e.vld = (cur >= 0);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        logic y;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            y = DATA[sel];
            check("sel", int'(sel), int'(e.sel));
            check("gnt", int'(gnt), int'(e.gnt));
            check("gnt_valid", int'(gnt_valid), int'(e.vld));
            check("mux_y", int'(y), int'(DATA[e.sel]));
            check("gnt_eq_vld_sel", int'(gnt),
                  int'(8'({7'd0, gnt_valid}) << sel));
        end
    end

    initial begin
        logic [7:0] served;
        rst = 1'b1;
        req = 8'h00;
        // reset with all requesting, then first grant goes to 0
        drive(1, 8'hFF);
        drive(1, 8'hFF);
        drive(0, 8'hFF);
        drive(0, 8'h00);
        drive(0, 8'h00);
        // single requester 5
        drive(1, 8'h00);
        repeat (5) drive(0, 8'h20);
        repeat (3) drive(0, 8'h00);
        // round-robin order, each grantee drops after one cycle
        drive(1, 8'h00);
        served = 8'h00;
        repeat (9) begin
            drive(0, 8'hFF & ~served);
            if (cur >= 0) served[cur] = 1'b1;
        end
        drive(0, 8'h00);
        // fairness after release
        drive(1, 8'h00);
        drive(0, 8'h09);
        drive(0, 8'h00);
        drive(0, 8'h09);
        drive(0, 8'h01);
        drive(0, 8'h00);
        // mux integration with 0 and 7
        drive(0, 8'h81);
        drive(0, 8'h80);
        drive(0, 8'h00);
        // sustained contention: preemption or indefinite hold
        drive(1, 8'h00);
        repeat (20) drive(0, 8'h03);
        drive(0, 8'h00);
        // reset mid-grant
        drive(0, 8'h10);
        drive(1, 8'h10);
        drive(0, 8'h00);
        // random traffic with sticky requests and rare resets
        for (int n = 0; n < 400; n++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 3) != 0 && cur >= 0) r[cur] = 1'b1;
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            drive($urandom_range(0, 99) == 0, r);
        end
        repeat (2) @(negedge clk);
        check("queue_drained", q.size(), 0);
        done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: sim time exceeded");
            $fatal(1, "timeout");
        end
    end

endmodule
